// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared state encoding and trigger mode constants for the ADC capture sequencer
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

endpackage

// File: rtl/adc_trig_detect.sv
// rtl/adc_trig_detect.sv - two-stage ADC sample pipeline and threshold-crossing trigger detector
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int PRECISION = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRECISION-1:0] adc_code,
  input  logic [1:0]           trig_mode,
  input  logic [PRECISION-1:0] trig_level,
  output logic [PRECISION-1:0] sample_out,
  output logic                 trig_hit
);

  logic [PRECISION-1:0] s1;
  logic [PRECISION-1:0] s2;
  logic                 rise_hit;
  logic                 fall_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= adc_code;
      s2 <= s1;
    end
  end

  // s1 is the newest sample, s2 the one before it
  assign rise_hit   = (s2 < trig_level) && (s1 >= trig_level);
  assign fall_hit   = (s2 >= trig_level) && (s1 < trig_level);
  assign sample_out = s2;

  always_comb begin
    trig_hit = 1'b1;
    case (trig_mode)
      TRIG_RISE: trig_hit = rise_hit;
      TRIG_FALL: trig_hit = fall_hit;
      default:   trig_hit = 1'b1;
    endcase
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - arms on a start edge, waits for a trigger, then writes capture_len samples to the FIFO
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int PRECISION = 10,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           trig_mode,
  input  logic [PRECISION-1:0] trig_level,
  input  logic [LEN_WIDTH-1:0] capture_len,
  input  logic [PRECISION-1:0] adc_code,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [PRECISION-1:0] fifo_din,
  output logic [1:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [LEN_WIDTH-1:0] samples_written
);

  state_t               state_q;
  logic                 start_d;
  logic                 start_p;
  logic                 trig_hit;
  logic [LEN_WIDTH-1:0] len_q;
  logic [1:0]           mode_q;
  logic [PRECISION-1:0] level_q;

  adc_trig_detect #(
    .PRECISION (PRECISION)
  ) u_trig (
    .clk        (clk),
    .rst        (rst),
    .adc_code   (adc_code),
    .trig_mode  (mode_q),
    .trig_level (level_q),
    .sample_out (fifo_din),
    .trig_hit   (trig_hit)
  );

  assign start_p    = start & ~start_d;
  // abort gates the write in the same cycle so an aborted capture never writes again
  assign fifo_wr_en = (state_q == CAPTURE) & ~fifo_full & ~abort;
  assign state      = state_q;
  assign busy       = (state_q == ARMED) || (state_q == CAPTURE);
  assign done       = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      start_d         <= 1'b0;
      len_q           <= '0;
      mode_q          <= TRIG_IMM;
      level_q         <= '0;
      samples_written <= '0;
      overflow        <= 1'b0;
    end else begin
      start_d <= start;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start_p) begin
              len_q           <= capture_len;
              mode_q          <= trig_mode;
              level_q         <= trig_level;
              samples_written <= '0;
              overflow        <= 1'b0;
              state_q         <= (capture_len == '0) ? DONE : ARMED;
            end
          end
          ARMED: begin
            if (trig_hit) state_q <= CAPTURE;
          end
          CAPTURE: begin
            if (fifo_full) begin
              overflow <= 1'b1;
            end else begin
              samples_written <= samples_written + 1'b1;
              if (samples_written == len_q - 1'b1) state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - directed self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  trig_mode;
  logic [9:0]  trig_level;
  logic [15:0] capture_len;
  logic [9:0]  adc_code;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [9:0]  fifo_din;
  logic [1:0]  state;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] samples_written;

  int n_checks = 0;
  int n_errors = 0;
  int wr_q[$];
  int stim[$];
  int cap_cycles;
  int a;
  bit ramp_en;

  adc_capture_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .trig_mode       (trig_mode),
    .trig_level      (trig_level),
    .capture_len     (capture_len),
    .adc_code        (adc_code),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_din        (fifo_din),
    .state           (state),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .samples_written (samples_written)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // record the cycle in progress at the negedge, then cross the edge and drive
  task automatic tick();
    @(negedge clk);
    if (!rst && fifo_wr_en) wr_q.push_back(32'(fifo_din));
    if (state == 2'd2) cap_cycles++;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (stim.size() > 0) adc_code = 10'(stim.pop_front());
    else if (ramp_en) adc_code = adc_code + 10'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic kick(input int len, input int mode, input int lvl);
    capture_len = 16'(len);
    trig_mode   = 2'(mode);
    trig_level  = 10'(lvl);
    start       = 1'b1;
    wr_q.delete();
    cap_cycles  = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; trig_mode = 2'd0; trig_level = '0;
    capture_len = '0; adc_code = '0; fifo_full = 1'b0; ramp_en = 1'b0; cap_cycles = 0;
    ticks(2);
    rst = 1'b0;
    #1;
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_wr_en", 32'(fifo_wr_en), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_count", 32'(samples_written), 0);
    check_eq("rst_din", 32'(fifo_din), 0);

    // immediate trigger, ramp input, len 4
    ramp_en = 1'b1;
    ticks(3);
    a = 32'(adc_code);
    kick(4, 0, 0);
    tick();
    check_eq("imm_armed", 32'(state), 1);
    check_eq("imm_busy", 32'(busy), 1);
    tick();
    check_eq("imm_capture", 32'(state), 2);
    check_eq("imm_first_wr_en", 32'(fifo_wr_en), 1);
    ticks(6);
    check_eq("imm_writes", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) check_eq("imm_data", wr_q[i], a + i);
    check_eq("imm_cap_cycles", cap_cycles, 4);
    check_eq("imm_done", 32'(done), 1);
    check_eq("imm_count", 32'(samples_written), 4);
    check_eq("imm_overflow", 32'(overflow), 0);
    check_eq("imm_busy_end", 32'(busy), 0);

    // rising crossing of 512
    ramp_en  = 1'b0;
    adc_code = 10'd500;
    tick();
    kick(3, 1, 512);
    stim = '{500, 500, 510, 520, 530, 540};
    ticks(3);
    check_eq("rise_wait_armed", 32'(state), 1);
    check_eq("rise_wait_nowr", wr_q.size(), 0);
    ticks(9);
    check_eq("rise_writes", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      check_eq("rise_d0", wr_q[0], 520);
      check_eq("rise_d1", wr_q[1], 530);
      check_eq("rise_d2", wr_q[2], 540);
    end
    check_eq("rise_cap_cycles", cap_cycles, 3);
    check_eq("rise_done", 32'(done), 1);

    // FIFO full for two mid-capture cycles
    ramp_en = 1'b1;
    tick();
    a = 32'(adc_code);
    kick(5, 0, 0);
    ticks(4);
    fifo_full = 1'b1;
    #1;
    check_eq("full_wr_en", 32'(fifo_wr_en), 0);
    ticks(2);
    fifo_full = 1'b0;
    ticks(6);
    check_eq("full_writes", wr_q.size(), 5);
    if (wr_q.size() == 5) begin
      check_eq("full_d0", wr_q[0], a);
      check_eq("full_d1", wr_q[1], a + 1);
      check_eq("full_d2", wr_q[2], a + 4);
      check_eq("full_d4", wr_q[4], a + 6);
    end
    check_eq("full_cap_cycles", cap_cycles, 7);
    check_eq("full_overflow", 32'(overflow), 1);
    check_eq("full_count", 32'(samples_written), 5);
    check_eq("full_done", 32'(done), 1);

    // abort after 3 of 10 writes
    tick();
    a = 32'(adc_code);
    kick(10, 0, 0);
    ticks(5);
    abort = 1'b1;
    #1;
    check_eq("abort_wr_en", 32'(fifo_wr_en), 0);
    tick();
    abort = 1'b0;
    check_eq("abort_state", 32'(state), 0);
    check_eq("abort_count", 32'(samples_written), 3);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_overflow", 32'(overflow), 0);
    check_eq("abort_writes", wr_q.size(), 3);
    if (wr_q.size() == 3) check_eq("abort_d2", wr_q[2], a + 2);

    // zero length goes straight to DONE
    kick(0, 0, 0);
    tick();
    check_eq("zero_state", 32'(state), 3);
    check_eq("zero_done", 32'(done), 1);
    ticks(3);
    check_eq("zero_writes", wr_q.size(), 0);
    check_eq("zero_count", 32'(samples_written), 0);

    // second start while ARMED is ignored, shadow len/mode/level kept
    ramp_en  = 1'b0;
    adc_code = 10'd10;
    tick();
    kick(5, 1, 1000);
    ticks(2);
    kick(2, 0, 0);
    ticks(3);
    check_eq("ign_still_armed", 32'(state), 1);
    check_eq("ign_nowr", wr_q.size(), 0);
    adc_code = 10'd1020;
    ticks(10);
    check_eq("ign_writes", wr_q.size(), 5);
    if (wr_q.size() == 5) begin
      check_eq("ign_d0", wr_q[0], 1020);
      check_eq("ign_d4", wr_q[4], 1020);
    end
    check_eq("ign_count", 32'(samples_written), 5);
    check_eq("ign_done", 32'(done), 1);

    // reset during CAPTURE, then a clean capture
    ramp_en = 1'b1;
    tick();
    kick(10, 0, 0);
    ticks(4);
    check_eq("mrst_pre_state", 32'(state), 2);
    rst = 1'b1;
    tick();
    check_eq("mrst_state", 32'(state), 0);
    check_eq("mrst_wr_en", 32'(fifo_wr_en), 0);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_done", 32'(done), 0);
    check_eq("mrst_overflow", 32'(overflow), 0);
    check_eq("mrst_count", 32'(samples_written), 0);
    check_eq("mrst_din", 32'(fifo_din), 0);
    rst = 1'b0;
    a = 32'(adc_code);
    kick(2, 0, 0);
    ticks(6);
    check_eq("post_writes", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check_eq("post_d0", wr_q[0], a);
      check_eq("post_d1", wr_q[1], a + 1);
    end
    check_eq("post_count", 32'(samples_written), 2);
    check_eq("post_done", 32'(done), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer between the ADC code bus and the ADC sample FIFO write port. It arms on a host start command and waits for an immediate, rising-edge or falling-edge threshold trigger. It then writes exactly `capture_len` samples into the FIFO, dropping samples while the FIFO is full and flagging them. All host-facing controls arrive as level signals from FrontPanel wire-ins, and all status returns via wire-outs.

## Interface
- `PRECISION`, 10, ADC code width
- `LEN_WIDTH`, 16, width of capture length and sample counter
- `clk` in 1: single clock, ADC sample clock domain
- `rst` in 1: reset; **one clock; reset is synchronous and active-high**
- `start` in 1: level from wire-in; only its rising edge acts
- `abort` in 1: level; while high, forces IDLE
- `trig_mode` in 2: 00 immediate, 01 rising crossing, 10 falling crossing, 11 treated as immediate
- `trig_level` in PRECISION: unsigned threshold
- `capture_len` in LEN_WIDTH: number of samples to write
- `adc_code` in PRECISION: raw ADC code, valid every `clk`
- `fifo_full` in 1: FIFO full flag, write-clock domain
- `fifo_wr_en` out 1: FIFO write enable
- `fifo_din` out PRECISION: FIFO write data
- `state` out 2: current FSM state
- `busy` out 1: state is ARMED or CAPTURE
- `done` out 1: state is DONE
- `overflow` out 1: sticky; at least one sample was dropped on full
- `samples_written` out LEN_WIDTH: number of writes in the current or last capture

## Operation
- **Input pipeline:**
  - `s1 <= adc_code` and `s2 <= s1` every cycle, unconditionally.
  - `fifo_din = s2`.
- **Start detection:** `start_d <= start`; `start_p = start & ~start_d`.
- **Trigger detection** (combinational, on `s1` = current and `s2` = previous sample):
  - Rising: `s2 < lvl && s1 >= lvl`.
  - Falling: `s2 >= lvl && s1 < lvl`.
  - Immediate: always true.
- **IDLE / DONE:**
  - On `start_p`: latch `capture_len`, `trig_mode` and `trig_level` into shadow registers.
  - Clear `samples_written` and `overflow`.
  - If the latched length is 0, go to DONE; otherwise go to ARMED.
- **ARMED:**
  - On trigger, go to CAPTURE.
  - The trigger sample is `s1` at the detect cycle. It is in `s2` on the first CAPTURE cycle, so it is the first sample written.
- **CAPTURE:**
  - `fifo_wr_en = (state==CAPTURE) & ~fifo_full`. This path is combinational from `fifo_full`.
  - On each write, `samples_written` increments.
  - On the write where `samples_written == len-1`, go to DONE.
  - In any CAPTURE cycle with `fifo_full=1`, no write occurs, that sample is lost, `overflow <= 1`, and the count does not advance.
- **Abort:** `abort=1` in any state gives IDLE next cycle.
  - `fifo_wr_en` is forced to 0 in that same cycle.
  - `samples_written` and `overflow` are held.
  - `done` is not set.
- **Priority:** `rst` > `abort` > `start_p`.
  - `start_p` in ARMED or CAPTURE is ignored.
  - Shadow registers are immune to input changes mid-capture.
- **Width and wrap:** `samples_written` is LEN_WIDTH unsigned and never wraps, because it stops at `len`. The maximum capture is 2^LEN_WIDTH−1 samples.

## Timing
- **Reset values:**
  - State IDLE.
  - `fifo_wr_en`, `busy`, `done` and `overflow` are 0.
  - `samples_written`, `s1`, `s2` and `start_d` are 0.
- **Latency:**
  - `adc_code` to `fifo_din` is 2 cycles.
  - `start` rising edge to ARMED is 1 cycle.
  - Immediate trigger: ARMED lasts exactly 1 cycle, so the first write is 2 cycles after the `start` edge.
- **Done timing:** `done` asserts the cycle after the last write and holds until `start_p`, `abort` or `rst`.
- **Capture duration:** with no full stalls, CAPTURE lasts exactly `len` cycles and produces `len` consecutive `s2` samples.
- **Reset mid-capture:** `fifo_wr_en` is 0 from the cycle after `rst` is sampled.

## Structure
- **Package `adc_capture_pkg`:**
  - State encoding: IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3.
  - Trigger mode constants: TRIG_IMM=2'd0, TRIG_RISE=2'd1, TRIG_FALL=2'd2.
- **Sub-module `adc_trig_detect`:** holds `s1`/`s2`, the comparators and the mode mux, and outputs `trig_hit`.
- The FSM, counter and flags stay in the top.

## Test plan
- **Immediate capture:**
  - Stimulus: `adc_code` ramp 0,1,2,… from reset; mode 00; len 4; `start` edge.
  - Required: exactly 4 writes of consecutive values; `done=1`; `samples_written=4`; `overflow=0`.
- **Rising trigger:**
  - Stimulus: `trig_level=512`; input 500,510,520,530,540; mode 01; len 3.
  - Required: writes 520,530,540; no write while below the threshold.
- **FIFO full stall:**
  - Stimulus: len 5; `fifo_full=1` for 2 cycles mid-capture.
  - Required: 5 writes total; `overflow=1`; CAPTURE lasts 7 cycles; the 2 samples present during full are absent.
- **Abort:**
  - Stimulus: `abort` pulse after 3 of 10 writes.
  - Required: `fifo_wr_en=0` that cycle; state IDLE next cycle; `samples_written=3`; `done=0`.
- **Zero length and ignored start:**
  - Stimulus (a): len 0.
  - Required (a): DONE next cycle with no writes.
  - Stimulus (b): a second `start` edge while ARMED.
  - Required (b): ignored; shadow length unchanged.
- **Reset mid-capture:**
  - Stimulus: `rst` during CAPTURE.
  - Required: all outputs reach reset values 1 cycle later; a new `start` then runs a clean capture.
